// File: rtl/tx_port_engine.sv
// tx_port_engine: processor-mapped 8N1 serial transmitter with holding register,
// overrun/interrupt status and back-to-back frame chaining.
module tx_port_engine #(
    parameter int unsigned BAUD_DIV = 10416,
    parameter logic [15:0] TX_PORT = 16'h0000,
    parameter logic [15:0] STAT_PORT = 16'h0001
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] PORT_ID,
    input  logic [15:0] OUT_PORT,
    input  logic        WRITE_STROBE,
    input  logic        READ_STROBE,
    input  logic        INTERRUPT_ACK,
    output logic [15:0] READ_DATA,
    output logic        INTERRUPT,
    output logic        TX
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);
    state_t state, state_n;
    logic [15:0] baud, baud_n;
    logic [2:0] bitc, bitc_n;
    logic [7:0] shift, shift_n, hold;
    logic tx, tx_n, hold_full, overrun, irq;
    logic wr, rd, tick, take, bypass, done, busy;
    logic unused;
    assign unused = &{1'b0, OUT_PORT[15:8]};
    assign wr = WRITE_STROBE && PORT_ID == TX_PORT;
    assign rd = READ_STROBE && PORT_ID == STAT_PORT;
    assign tick = baud == LAST;
    assign busy = state != IDLE;
    assign TX = tx;
    assign INTERRUPT = irq;
    assign READ_DATA = (PORT_ID == STAT_PORT) ? {12'b0, irq, overrun, hold_full, busy} : 16'h0000;
    always_comb begin
        state_n = state;
        baud_n = baud;
        bitc_n = bitc;
        shift_n = shift;
        tx_n = tx;
        take = 1'b0;
        bypass = 1'b0;
        done = 1'b0;
        case (state)
            IDLE: if (hold_full) begin
                state_n = START;
                shift_n = hold;
                take = 1'b1;
                tx_n = 1'b0;
                baud_n = '0;
            end
            START: if (tick) begin
                state_n = DATA;
                baud_n = '0;
                bitc_n = '0;
                tx_n = shift[0];
            end else baud_n = baud + 16'd1;
            DATA: if (tick) begin
                baud_n = '0;
                if (bitc == 3'd7) begin
                    state_n = STOP;
                    tx_n = 1'b1;
                end else begin
                    bitc_n = bitc + 3'd1;
                    shift_n = shift >> 1;
                    tx_n = shift[1];
                end
            end else baud_n = baud + 16'd1;
            default: if (tick) begin
                baud_n = '0;
                done = 1'b1;
                // A write landing on the final STOP edge bypasses the holding register
                if (hold_full) begin
                    state_n = START;
                    shift_n = hold;
                    take = 1'b1;
                    tx_n = 1'b0;
                end else if (wr) begin
                    state_n = START;
                    shift_n = OUT_PORT[7:0];
                    bypass = 1'b1;
                    tx_n = 1'b0;
                end else state_n = IDLE;
            end else baud_n = baud + 16'd1;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            tx <= 1'b1;
            hold <= '0;
            hold_full <= 1'b0;
            overrun <= 1'b0;
            irq <= 1'b0;
            baud <= '0;
            bitc <= '0;
            shift <= '0;
        end else begin
            state <= state_n;
            tx <= tx_n;
            baud <= baud_n;
            bitc <= bitc_n;
            shift <= shift_n;
            hold <= (wr && !hold_full) ? OUT_PORT[7:0] : hold;
            hold_full <= take ? 1'b0 : (wr && !hold_full && !bypass) ? 1'b1 : hold_full;
            overrun <= (wr && hold_full) ? 1'b1 : rd ? 1'b0 : overrun;
            irq <= done ? 1'b1 : INTERRUPT_ACK ? 1'b0 : irq;
        end
    end
endmodule

// File: doc/tx_port_engine.md
TX_PORT_ENGINE -- requirements
Module: tx_port_engine

Interface
REQ-001 Parameter BAUD_DIV, default 10416, clocks per serial bit period (legal range 2..65535).
REQ-002 Parameter TX_PORT, default 16'h0000, PORT_ID value selecting the transmit-data register.
REQ-003 Parameter STAT_PORT, default 16'h0001, PORT_ID value selecting the status register.
REQ-004 CLK  input  1  system clock; all state changes on its rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 PORT_ID  input  16  processor port address.
REQ-007 OUT_PORT  input  16  processor write data; only bits [7:0] are used.
REQ-008 WRITE_STROBE  input  1  processor write qualifier, one cycle per write.
REQ-009 READ_STROBE  input  1  processor read qualifier, one cycle per read.
REQ-010 INTERRUPT_ACK  input  1  processor acknowledge; clears the pending interrupt.
REQ-011 READ_DATA  output  16  status readback, routed to the processor IN_PORT.
REQ-012 INTERRUPT  output  1  level interrupt request to the processor.
REQ-013 TX  output  1  serial line, 8N1, LSB first, idle high, registered.

Function
REQ-014 Write capture: on a clock edge with WRITE_STROBE=1 and PORT_ID=TX_PORT: if the holding register is empty, OUT_PORT[7:0] is latched and hold_full is set to 1.
REQ-015 Overrun: on a write with hold_full=1, the written data is discarded, the held byte is kept, and the sticky overrun flag is set to 1.
REQ-016 FSM states are IDLE, START, DATA, STOP; busy=1 in every state except IDLE.
REQ-017 IDLE to START: on any edge where the state is IDLE and hold_full=1, the held byte is moved to the shift register, hold_full is cleared, and TX is driven to 0 on the same edge.
REQ-018 Timing: a write to an idle engine at edge N gives TX=0 after edge N+1.
REQ-019 Baud counter: each of START, the 8 DATA bits and STOP lasts exactly BAUD_DIV clocks; the counter runs from 0 to BAUD_DIV-1, then wraps to 0 and advances the bit.
REQ-020 DATA: TX carries shift[0] for each bit, bit 0 first; a 3-bit counter counts the bits; the 8th bit is followed by STOP.
REQ-021 STOP: TX=1 for BAUD_DIV clocks; one complete frame is 10*BAUD_DIV clocks.
REQ-022 End of STOP with hold_full=1: the engine goes directly to START on that edge; there is no idle cycle between frames.
REQ-023 End of STOP with hold_full=0: the engine goes to IDLE and TX stays 1.
REQ-024 A write captured on the same edge as the end of STOP is sent back-to-back, without an idle gap.
REQ-025 Interrupt set: irq_pending is set to 1 on the edge that completes a STOP bit; INTERRUPT equals irq_pending.
REQ-026 Interrupt clear: INTERRUPT_ACK=1 clears irq_pending, except that a set event on the same edge wins and irq_pending stays 1.
REQ-027 Status word: READ_DATA = {12'b0, irq_pending, overrun, hold_full, busy} when PORT_ID=STAT_PORT; otherwise READ_DATA = 16'h0000.
REQ-028 READ_DATA is combinational from registered state.
REQ-029 Overrun clear: an edge with READ_STROBE=1 and PORT_ID=STAT_PORT clears overrun; a new overrun on the same edge wins and overrun stays 1.
REQ-030 Writes to any other PORT_ID, and reads of any other PORT_ID, have no effect on state.

Reset
REQ-031 An edge with RESET=1 sets: state=IDLE, TX=1, hold_full=0, overrun=0, irq_pending=0, and baud, bit and shift registers to 0.
REQ-032 Reset mid-frame aborts the frame; TX=1 after that edge and no interrupt is raised.
REQ-033 RESET has priority over every simultaneous strobe, including WRITE_STROBE, READ_STROBE and INTERRUPT_ACK.

Verification (BAUD_DIV=4 unless stated)
REQ-034 Single frame: write 8'hA5 to TX_PORT -> TX reads 0,1,0,1,0,0,1,0,1,1, each bit held 4 clocks, starting at edge N+1; INTERRUPT rises at the edge 40 clocks after N+1.
REQ-035 Back-to-back: write 8'h01, then write 8'h80 while the first frame is in DATA -> two frames with no idle cycle between them; INTERRUPT is set after each STOP.
REQ-036 Overrun: with a frame running and hold_full=1, write 8'hFF -> the status read returns 16'h0007, the next status read returns 16'h0003, and 8'hFF is never transmitted.
REQ-037 Interrupt race: INTERRUPT_ACK asserted on the edge that completes a STOP -> INTERRUPT stays 1; a later ACK clears it to 0.
REQ-038 Reset mid-frame: assert RESET during DATA bit 3 -> TX=1 and READ_DATA at STAT_PORT = 16'h0000 after the edge; a subsequent write transmits normally.
REQ-039 Port decode: write to PORT_ID 16'h0002 -> TX stays 1 and the status read returns 16'h0000; repeat REQ-034 with BAUD_DIV=2 -> frame length is 20 clocks.
